// File: rtl/pc_unit.sv
// Fetch-stage program counter: reset/exception vectoring, branch redirect, stall,
// and a circular return-address stack that keeps the newest RAS_DEPTH links.
module pc_unit #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 'h400,
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR   = 'h180,
  parameter int unsigned           INSTR_BYTES  = 4,
  parameter int unsigned           RAS_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         redirect_valid,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc,
  input  logic                         exception,
  input  logic                         ras_push,
  input  logic                         ras_pop,
  output logic [ADDR_WIDTH-1:0]        pc,
  output logic [ADDR_WIDTH-1:0]        link_addr,
  output logic [ADDR_WIDTH-1:0]        epc,
  output logic [ADDR_WIDTH-1:0]        bad_addr,
  output logic [1:0]                   cause,
  output logic                         exc_taken,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ras_underflow
);

  localparam int unsigned           PTR_W      = $clog2(RAS_DEPTH);
  localparam int unsigned           CNT_W      = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);
  localparam logic [CNT_W-1:0]      CNT_MAX    = CNT_W'(RAS_DEPTH);
  localparam logic [1:0]            CAUSE_NONE = 2'd0;
  localparam logic [1:0]            CAUSE_EXT  = 2'd1;
  localparam logic [1:0]            CAUSE_MIS  = 2'd2;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] epc_q, epc_d;
  logic [ADDR_WIDTH-1:0] bad_addr_q, bad_addr_d;
  logic [1:0]            cause_q, cause_d;
  logic                  exc_taken_q, exc_taken_d;
  logic                  underflow_q, underflow_d;
  logic [CNT_W-1:0]      ras_cnt_q, ras_cnt_d;
  logic [PTR_W-1:0]      ras_top_q, ras_top_d;
  logic [ADDR_WIDTH-1:0] ras_mem_q [RAS_DEPTH];

  logic                  misaligned;
  logic                  take_exc;
  logic                  is_empty;
  logic                  is_full;
  logic                  pop_req;
  logic                  pop_hit;
  logic                  pop_under;
  logic                  push_en;
  logic                  ras_wr_en;
  logic [PTR_W-1:0]      ras_wr_idx;
  logic [ADDR_WIDTH-1:0] next_seq;
  logic [ADDR_WIDTH-1:0] top_entry;

  // Masking (instead of slicing) keeps INSTR_BYTES=1 legal: the mask is zero.
  assign misaligned = redirect_valid && ((redirect_pc & ALIGN_MASK) != '0);
  assign take_exc   = exception || misaligned;
  assign next_seq   = pc_q + STEP;
  assign is_empty   = (ras_cnt_q == '0);
  assign is_full    = (ras_cnt_q == CNT_MAX);
  assign top_entry  = ras_mem_q[ras_top_q];

  // A redirect outranks a return, so the pop is dropped when both arrive.
  assign pop_req    = ras_pop && !stall && !take_exc && !redirect_valid;
  assign pop_hit    = pop_req && !is_empty;
  assign pop_under  = pop_req && is_empty;
  assign push_en    = ras_push && !stall && !take_exc;

  always_comb begin
    pc_d        = pc_q;
    epc_d       = epc_q;
    bad_addr_d  = bad_addr_q;
    cause_d     = cause_q;
    exc_taken_d = 1'b0;
    underflow_d = 1'b0;
    if (exception) begin
      pc_d        = EXC_VECTOR;
      epc_d       = pc_q;
      cause_d     = CAUSE_EXT;
      exc_taken_d = 1'b1;
    end else if (misaligned) begin
      pc_d        = EXC_VECTOR;
      epc_d       = pc_q;
      bad_addr_d  = redirect_pc;
      cause_d     = CAUSE_MIS;
      exc_taken_d = 1'b1;
    end else if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (pop_hit) begin
      pc_d = top_entry;
    end else if (pop_under) begin
      underflow_d = 1'b1;
      pc_d        = next_seq;
    end else if (!stall) begin
      pc_d = next_seq;
    end
  end

  // Push+pop on a non-empty stack swaps the top in place; a plain push when
  // full advances the pointer onto the oldest slot, overwriting it.
  always_comb begin
    ras_top_d  = ras_top_q;
    ras_cnt_d  = ras_cnt_q;
    ras_wr_en  = 1'b0;
    ras_wr_idx = ras_top_q;
    if (push_en && pop_hit) begin
      ras_wr_en = 1'b1;
    end else if (push_en) begin
      ras_wr_en  = 1'b1;
      ras_wr_idx = ras_top_q + PTR_W'(1);
      ras_top_d  = ras_top_q + PTR_W'(1);
      if (!is_full) ras_cnt_d = ras_cnt_q + CNT_W'(1);
    end else if (pop_hit) begin
      ras_top_d = ras_top_q - PTR_W'(1);
      ras_cnt_d = ras_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_VECTOR;
      epc_q       <= '0;
      bad_addr_q  <= '0;
      cause_q     <= CAUSE_NONE;
      exc_taken_q <= 1'b0;
      underflow_q <= 1'b0;
      ras_cnt_q   <= '0;
      ras_top_q   <= PTR_W'(RAS_DEPTH - 1);
    end else begin
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      bad_addr_q  <= bad_addr_d;
      cause_q     <= cause_d;
      exc_taken_q <= exc_taken_d;
      underflow_q <= underflow_d;
      ras_cnt_q   <= ras_cnt_d;
      ras_top_q   <= ras_top_d;
    end
  end

  // Stack contents need no reset; only the count says what is valid.
  always_ff @(posedge clk) begin
    if (!rst && ras_wr_en) ras_mem_q[ras_wr_idx] <= next_seq;
  end

  assign pc            = pc_q;
  assign link_addr     = next_seq;
  assign epc           = epc_q;
  assign bad_addr      = bad_addr_q;
  assign cause         = cause_q;
  assign exc_taken     = exc_taken_q;
  assign ras_count     = ras_cnt_q;
  assign ras_empty     = is_empty;
  assign ras_full      = is_full;
  assign ras_underflow = underflow_q;

endmodule

// File: tb/tb_pc_unit.sv
// Table-driven check of pc_unit: each vector's expected state is queued when
// its inputs are driven and compared one cycle later after the rising edge.
module tb_pc_unit;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        exc;
    logic        push;
    logic        pop;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] bad;
    logic [1:0]  cause;
    logic        et;
    logic [2:0]  cnt;
    logic        unf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid, exception, ras_push, ras_pop;
  logic [31:0] redirect_pc;
  logic [31:0] pc, link_addr, epc, bad_addr;
  logic [1:0]  cause;
  logic        exc_taken, ras_empty, ras_full, ras_underflow;
  logic [2:0]  ras_count;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  pc_unit #(
    .ADDR_WIDTH(32), .RESET_VECTOR(32'h400), .EXC_VECTOR(32'h180),
    .INSTR_BYTES(4), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .exception(exception), .ras_push(ras_push),
    .ras_pop(ras_pop), .pc(pc), .link_addr(link_addr), .epc(epc),
    .bad_addr(bad_addr), .cause(cause), .exc_taken(exc_taken),
    .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_underflow(ras_underflow)
  );

  function automatic vec_t mk(logic r, logic s, logic rv, logic [31:0] rpc,
                              logic e, logic pu, logic po, logic [31:0] p,
                              logic [31:0] ep, logic [31:0] bd, logic [1:0] c,
                              logic et, logic [2:0] n, logic u);
    vec_t v;
    v.rst = r; v.stall = s; v.rv = rv; v.rpc = rpc; v.exc = e;
    v.push = pu; v.pop = po; v.pc = p; v.epc = ep; v.bad = bd;
    v.cause = c; v.et = et; v.cnt = n; v.unf = u;
    return v;
  endfunction

  task automatic step(input vec_t v, input string tag);
    vec_t x;
    logic [31:0] exp_link;
    rst = v.rst; stall = v.stall; redirect_valid = v.rv; redirect_pc = v.rpc;
    exception = v.exc; ras_push = v.push; ras_pop = v.pop;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      x = exp_q.pop_front();
      exp_link = x.pc + 32'd4;
      if (pc !== x.pc || link_addr !== exp_link || epc !== x.epc ||
          bad_addr !== x.bad || cause !== x.cause || exc_taken !== x.et ||
          ras_count !== x.cnt || ras_empty !== (x.cnt == 3'd0) ||
          ras_full !== (x.cnt == 3'd4) || ras_underflow !== x.unf) begin
        n_bad++;
        $display("FAIL %s: got pc=%h link=%h epc=%h bad=%h cause=%0d et=%b cnt=%0d emp=%b full=%b unf=%b | want pc=%h link=%h epc=%h bad=%h cause=%0d et=%b cnt=%0d unf=%b",
                 tag, pc, link_addr, epc, bad_addr, cause, exc_taken, ras_count,
                 ras_empty, ras_full, ras_underflow, x.pc, exp_link, x.epc, x.bad,
                 x.cause, x.et, x.cnt, x.unf);
      end else begin
        $display("vec %s: pc=%h cnt=%0d cause=%0d et=%b unf=%b", tag, pc,
                 ras_count, cause, exc_taken, ras_underflow);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    exception = 1'b0; ras_push = 1'b0; ras_pop = 1'b0;
    // rst stall rv rpc exc push pop | pc epc bad cause et cnt unf
    // Reset and sequential fetch
    tbl.push_back(mk(1,0,0,32'h0,0,0,0, 32'h400,32'h0,32'h0,0,0,0,0));
    tbl.push_back(mk(1,0,0,32'h0,0,0,0, 32'h400,32'h0,32'h0,0,0,0,0));
    tbl.push_back(mk(1,0,0,32'h0,0,0,0, 32'h400,32'h0,32'h0,0,0,0,0));
    tbl.push_back(mk(0,0,0,32'h0,0,0,0, 32'h404,32'h0,32'h0,0,0,0,0));
    tbl.push_back(mk(0,0,0,32'h0,0,0,0, 32'h408,32'h0,32'h0,0,0,0,0));
    // Stall, then redirect overriding stall
    tbl.push_back(mk(0,1,0,32'h0,0,0,0, 32'h408,32'h0,32'h0,0,0,0,0));
    tbl.push_back(mk(0,1,0,32'h0,0,0,0, 32'h408,32'h0,32'h0,0,0,0,0));
    tbl.push_back(mk(0,1,1,32'h1000,0,0,0, 32'h1000,32'h0,32'h0,0,0,0,0));
    // Misaligned redirect, then external exception beats redirect
    tbl.push_back(mk(0,0,1,32'h500,0,0,0, 32'h500,32'h0,32'h0,0,0,0,0));
    tbl.push_back(mk(0,0,1,32'h602,0,0,0, 32'h180,32'h500,32'h602,2,1,0,0));
    tbl.push_back(mk(0,0,0,32'h0,0,0,0, 32'h184,32'h500,32'h602,2,0,0,0));
    tbl.push_back(mk(0,0,1,32'h2000,1,0,0, 32'h180,32'h184,32'h602,1,1,0,0));
    tbl.push_back(mk(0,0,0,32'h0,0,0,0, 32'h184,32'h184,32'h602,1,0,0,0));
    // JAL + return, then underflow
    tbl.push_back(mk(0,0,1,32'h400,0,0,0, 32'h400,32'h184,32'h602,1,0,0,0));
    tbl.push_back(mk(0,0,1,32'h800,0,1,0, 32'h800,32'h184,32'h602,1,0,1,0));
    tbl.push_back(mk(0,0,0,32'h0,0,0,0, 32'h804,32'h184,32'h602,1,0,1,0));
    tbl.push_back(mk(0,0,0,32'h0,0,0,1, 32'h404,32'h184,32'h602,1,0,0,0));
    tbl.push_back(mk(0,0,0,32'h0,0,0,1, 32'h408,32'h184,32'h602,1,0,0,1));
    tbl.push_back(mk(0,0,0,32'h0,0,0,0, 32'h40C,32'h184,32'h602,1,0,0,0));
    // Five pushes (links 0x10..0x50) wrap a 4-deep stack; pops are LIFO
    tbl.push_back(mk(0,0,1,32'hC,0,0,0, 32'hC,32'h184,32'h602,1,0,0,0));
    tbl.push_back(mk(0,0,1,32'h1C,0,1,0, 32'h1C,32'h184,32'h602,1,0,1,0));
    tbl.push_back(mk(0,0,1,32'h2C,0,1,0, 32'h2C,32'h184,32'h602,1,0,2,0));
    tbl.push_back(mk(0,0,1,32'h3C,0,1,0, 32'h3C,32'h184,32'h602,1,0,3,0));
    tbl.push_back(mk(0,0,1,32'h4C,0,1,0, 32'h4C,32'h184,32'h602,1,0,4,0));
    tbl.push_back(mk(0,0,1,32'h900,0,1,0, 32'h900,32'h184,32'h602,1,0,4,0));
    tbl.push_back(mk(0,0,0,32'h0,0,0,1, 32'h50,32'h184,32'h602,1,0,3,0));
    tbl.push_back(mk(0,0,0,32'h0,0,0,1, 32'h40,32'h184,32'h602,1,0,2,0));
    tbl.push_back(mk(0,0,0,32'h0,0,0,1, 32'h30,32'h184,32'h602,1,0,1,0));
    tbl.push_back(mk(0,0,0,32'h0,0,0,1, 32'h20,32'h184,32'h602,1,0,0,0));
    tbl.push_back(mk(0,0,0,32'h0,0,0,1, 32'h24,32'h184,32'h602,1,0,0,1));
    // Push+pop swap, push+pop on empty, stall suppression, exception suppression
    tbl.push_back(mk(0,0,0,32'h0,0,1,0, 32'h28,32'h184,32'h602,1,0,1,0));
    tbl.push_back(mk(0,0,0,32'h0,0,1,1, 32'h28,32'h184,32'h602,1,0,1,0));
    tbl.push_back(mk(0,0,0,32'h0,0,0,1, 32'h2C,32'h184,32'h602,1,0,0,0));
    tbl.push_back(mk(0,0,0,32'h0,0,1,1, 32'h30,32'h184,32'h602,1,0,1,1));
    tbl.push_back(mk(0,1,0,32'h0,0,0,1, 32'h30,32'h184,32'h602,1,0,1,0));
    tbl.push_back(mk(0,1,0,32'h0,0,1,0, 32'h30,32'h184,32'h602,1,0,1,0));
    tbl.push_back(mk(0,0,0,32'h0,1,1,1, 32'h180,32'h30,32'h602,1,1,1,0));
    tbl.push_back(mk(0,0,0,32'h0,0,0,1, 32'h30,32'h30,32'h602,1,0,0,0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("tbl%0d", i));

    // Reset mid-sequence with three entries and an exception pending
    step(mk(0,0,0,32'h0,0,1,0, 32'h34,32'h30,32'h602,1,0,1,0), "fill1");
    step(mk(0,0,0,32'h0,0,1,0, 32'h38,32'h30,32'h602,1,0,2,0), "fill2");
    step(mk(0,0,0,32'h0,0,1,0, 32'h3C,32'h30,32'h602,1,0,3,0), "fill3");
    step(mk(1,0,0,32'h0,1,1,0, 32'h400,32'h0,32'h0,0,0,0,0), "rst_mid");
    step(mk(0,0,0,32'h0,0,0,0, 32'h404,32'h0,32'h0,0,0,0,0), "post_rst");
    // Address wrap at the top of the space
    step(mk(0,0,1,32'hFFFF_FFFC,0,0,0, 32'hFFFF_FFFC,32'h0,32'h0,0,0,0,0), "to_top");
    step(mk(0,0,0,32'h0,0,0,0, 32'h0,32'h0,32'h0,0,0,0,0), "wrap");
    // Exception overrides stall; pulse lasts one cycle
    step(mk(0,1,0,32'h0,1,0,0, 32'h180,32'h0,32'h0,1,1,0,0), "exc_stall");
    step(mk(0,1,0,32'h0,0,0,0, 32'h180,32'h0,32'h0,1,0,0,0), "exc_clear");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the fetch stage. It holds a registered PC with a configurable reset vector and supports stall, branch/jump redirect, exception vectoring with EPC/bad-address capture, and a circular return-address stack (RAS) for link/return. It sits between the branch/jump resolution logic and instruction memory, and is the next generation of the fixed 32-bit, increment-by-4 PC.

Parameters:
ADDR_WIDTH, 32, width of PC and all address ports
RESET_VECTOR, 'h400, PC value held during and after reset
EXC_VECTOR, 'h180, PC loaded when any exception is taken
INSTR_BYTES, 4, increment step; must be a power of 2, at least 1
RAS_DEPTH, 4, return-address stack entries; must be a power of 2, at least 2

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hold PC; suppresses increment, ras_push and ras_pop
redirect_valid  in  1  take redirect_pc next cycle (branch/jump)
redirect_pc  in  ADDR_WIDTH  branch/jump target
exception  in  1  external exception request
ras_push  in  1  push link_addr onto RAS (jump-and-link)
ras_pop  in  1  return: load PC from RAS top
pc  out  ADDR_WIDTH  current fetch address (registered)
link_addr  out  ADDR_WIDTH  combinational pc + INSTR_BYTES, modulo 2^ADDR_WIDTH
epc  out  ADDR_WIDTH  PC at the last exception
bad_addr  out  ADDR_WIDTH  offending target of the last misaligned redirect
cause  out  2  last exception cause: 0 none, 1 external, 2 misaligned redirect
exc_taken  out  1  one-cycle pulse, registered, on the cycle after an exception is accepted
ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
ras_empty  out  1  ras_count == 0
ras_full  out  1  ras_count == RAS_DEPTH
ras_underflow  out  1  one-cycle registered pulse: pop attempted while empty

Behaviour:
- Reset (rst=1 at the edge, overrides all other inputs): pc=RESET_VECTOR, epc=0, bad_addr=0, cause=0, exc_taken=0, ras_count=0, ras_underflow=0. RAS contents are don't-care. After reset, link_addr = RESET_VECTOR+INSTR_BYTES.
- Misaligned redirect: redirect_valid=1 and redirect_pc[log2(INSTR_BYTES)-1:0] != 0. Never possible when INSTR_BYTES=1.
- Per-cycle next-PC priority, highest first:
  1. exception=1: pc<=EXC_VECTOR, epc<=pc, cause<=1, exc_taken<=1.
  2. Misaligned redirect: pc<=EXC_VECTOR, epc<=pc, bad_addr<=redirect_pc, cause<=2, exc_taken<=1.
  3. Aligned redirect: pc<=redirect_pc.
  4. ras_pop=1 and stall=0, RAS not empty: pc<=top entry, ras_count decrements.
  5. ras_pop=1 and stall=0, RAS empty: ras_underflow<=1, pc<=pc+INSTR_BYTES.
  6. stall=1: pc holds.
  7. Otherwise: pc<=pc+INSTR_BYTES.
- Exception and redirect override stall. Cases 1 and 2 suppress ras_push and ras_pop in that cycle (no RAS change).
- cause, epc and bad_addr are sticky until the next exception. exc_taken and ras_underflow are 0 in every cycle they are not set.
- ras_push (stall=0, no exception):
  - Writes link_addr of the current cycle at the top; count increments.
  - When full, overwrites the oldest entry via circular pointer; ras_count saturates at RAS_DEPTH.
  - Allowed in the same cycle as an aligned redirect (JAL: redirect + push).
- ras_push and ras_pop in the same cycle (RAS not empty): PC loads the old top, the top is replaced by link_addr, and ras_count is unchanged. If the RAS is empty, the pop underflows and the push proceeds normally.
- Pop after wrap returns entries in LIFO order. Only the newest RAS_DEPTH entries survive.
- All PC arithmetic wraps modulo 2^ADDR_WIDTH with no flag. Example: pc='hFFFF_FFFC, INSTR_BYTES=4 gives next pc=0.
- Latency: every control input affects pc at the next rising edge. No combinational path from inputs to pc.

Test Plan:
1. Hold rst 3 cycles, then release with no inputs -> pc=0x400 during reset, then 0x404, 0x408, 0x40C; link_addr=pc+4 each cycle.
2. At pc=0x408, assert stall 2 cycles, then redirect_valid with redirect_pc=0x1000 under stall -> pc holds 0x408 twice, then 0x1000.
3. At pc=0x500, redirect to 0x602 -> pc=0x180, epc=0x500, bad_addr=0x602, cause=2, exc_taken pulses 1 cycle. Then assert exception with redirect_valid -> cause=1, redirect ignored.
4. From pc=0x400, JAL to 0x800 (redirect+push), then at 0x804 assert ras_pop -> RAS holds 0x404, count=1, then pc=0x404, count=0. Another pop -> ras_underflow pulse, pc=0x408.
5. RAS_DEPTH=4: five pushes of 0x10,0x20,0x30,0x40,0x50 -> count saturates at 4. Four pops yield 0x50,0x40,0x30,0x20; fifth pop underflows.
6. Assert rst mid-sequence with count=3 and exception asserted -> next cycle pc=0x400, count=0, cause=0, exc_taken=0. Separately, set pc to 'hFFFF_FFFC -> increment gives pc=0.
